// File: rtl/mul_div_unit_if.sv
// Operand, MTHI/MTLO and result bundle between the control unit / register file and mul_div_unit.
interface mul_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic [1:0]            i_op;
    logic [DATA_WIDTH-1:0] i_a;
    logic [DATA_WIDTH-1:0] i_b;
    logic                  i_hi_we;
    logic                  i_lo_we;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  o_busy;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_hi;
    logic [DATA_WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_a, i_b, i_hi_we, i_lo_we, i_wdata,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_hi_we, i_lo_we, i_wdata,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative one-bit-per-clock HI/LO multiply/divide unit with MTHI/MTLO access.
// Define MUL_DIV_UNIT_DIV_EN to build the divider; otherwise DIV/DIVU run full latency and leave HI/LO as-is.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mul_div_unit_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic [DW-1:0]  acc_q, acc_d;      // product upper half / partial remainder
    logic [DW-1:0]  low_q, low_d;      // multiplier shifting out, or dividend shifting out / quotient in
    logic [DW-1:0]  opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic           neg_res_q, neg_res_d;
    logic [DW-1:0]  hi_q, hi_d;
    logic [DW-1:0]  lo_q, lo_d;
    logic           done_q, done_d;

    logic           start_signed;
    logic [DW-1:0]  mag_a;
    logic [DW-1:0]  mag_b;
    logic [DW:0]    mul_sum;
    logic [2*DW-1:0] product;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic           neg_rem_q, neg_rem_d;
    logic           div0_q, div0_d;
    logic [DW:0]    div_shift;
    logic [DW-1:0]  div_diff;
    logic           div_fits;
`endif

    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v, input logic is_signed);
        return (is_signed && v[DW-1]) ? (~v + 1'b1) : v;
    endfunction

    assign start_signed = ~bus.i_op[0];
    assign mag_a        = magnitude(bus.i_a, start_signed);
    assign mag_b        = magnitude(bus.i_b, start_signed);

    assign mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : {(DW+1){1'b0}});
    assign product = neg_res_q ? (~{acc_q, low_q} + 1'b1) : {acc_q, low_q};

`ifdef MUL_DIV_UNIT_DIV_EN
    // The true difference is always below the divisor when it is kept, so DW bits suffice.
    assign div_shift = {acc_q, low_q[DW-1]};
    assign div_fits  = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[DW-1:0] - opnd_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    is_div_d  = bus.i_op[1];
                    acc_d     = '0;
                    low_d     = bus.i_op[1] ? mag_a : mag_b;
                    opnd_d    = bus.i_op[1] ? mag_b : mag_a;
                    neg_res_d = start_signed & (bus.i_a[DW-1] ^ bus.i_b[DW-1]);
`ifdef MUL_DIV_UNIT_DIV_EN
                    neg_rem_d = start_signed & bus.i_a[DW-1];
                    div0_d    = (bus.i_b == '0);
`endif
                end else begin
                    if (bus.i_hi_we) hi_d = bus.i_wdata;
                    if (bus.i_lo_we) lo_d = bus.i_wdata;
                end
            end

            S_RUN: begin
                if (!is_div_q) begin
                    acc_d = mul_sum[DW:1];
                    low_d = {mul_sum[0], low_q[DW-1:1]};
                end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (div_fits) begin
                        acc_d = div_diff;
                        low_d = {low_q[DW-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[DW-1:0];
                        low_d = {low_q[DW-2:0], 1'b0};
                    end
`endif
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = product[2*DW-1:DW];
                    lo_d = product[DW-1:0];
                end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    // Divide by zero leaves the dividend as remainder; sign fix-up restores the original rs.
                    lo_d = div0_q    ? '1 : (neg_res_q ? (~low_q + 1'b1) : low_q);
                    hi_d = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
`endif
        end
    end

    assign bus.o_busy = (state_q != S_IDLE);
    assign bus.o_done = done_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and consumes the two read-port operands (rs, rt) for MULT/MULTU/DIV/DIVU. It holds the architectural HI and LO registers and serves MFHI/MFLO reads and MTHI/MTLO writes. Each operation is a shift-add or restoring-divide loop of one bit per clock, with a busy/done handshake so the control unit can stall.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; the iteration count equals DATA_WIDTH
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  begin the operation in i_op; sampled only in IDLE
- i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_a  in  DATA_WIDTH  rs operand (multiplicand / dividend), from register-file read port 1
- i_b  in  DATA_WIDTH  rt operand (multiplier / divisor), from register-file read port 2
- i_hi_we  in  1  MTHI write enable
- i_lo_we  in  1  MTLO write enable
- i_wdata  in  DATA_WIDTH  MTHI/MTLO data
- o_busy  out  1  operation in progress; the control unit stalls MFHI/MFLO/MTHI/MTLO/start while this is high
- o_done  out  1  one-cycle pulse when HI/LO take the result
- o_hi  out  DATA_WIDTH  HI register
- o_lo  out  DATA_WIDTH  LO register

## Operation
- States:
  - IDLE: accepts start.
  - RUN: DATA_WIDTH iterations.
  - FIX: sign correction and HI/LO write.
  - IDLE.
- IDLE with i_start=1:
  - Latch the magnitudes of i_a and i_b. Signed ops take the two's-complement absolute value; unsigned ops take the raw value.
  - Record the result signs and op.
  - Clear the iteration counter and go to RUN.
- RUN, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper accumulator. Then shift the {acc, multiplier} pair right by 1.
- RUN, divide: restoring algorithm. Shift the {rem, quot} pair left by 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB.
- Counter reaching DATA_WIDTH-1 in RUN moves the state to FIX.
- FIX, multiply: for MULT with differing operand signs, negate the 64-bit product. {HI,LO} = product.
- FIX, divide: LO = quotient, HI = remainder.
  - DIV: negate the quotient if the operand signs differ.
  - DIV: the remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): LO = all ones, HI = original i_a. Takes the normal latency; no trap.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: in IDLE with no start, the enabled register(s) take i_wdata at the edge. They are ignored while busy and on the start-accept edge.
- i_start while busy: ignored. The operands are not re-latched.
- HI/LO change only on the FIX edge, an MTHI/MTLO write, or reset.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, o_hi=0, o_lo=0, o_busy=0, o_done=0.
- Reset mid-operation aborts the operation. HI/LO are 0 after reset, not partial results.
- Start sampled at edge E0:
  - o_busy is 1 from after E0 through E0+33 (RUN E0..E32, FIX until E33).
  - At E33, HI/LO are written and o_done=1 for exactly one cycle; o_busy=0 after E33.
- Latency is DATA_WIDTH+1 edges from the start edge to the result for every op and operand value. There is no early termination.
- A new i_start may be sampled in the same cycle o_done is high, i.e. back-to-back ops every 34 cycles.
- o_hi/o_lo are registered and visible the cycle after the write edge.

## Configuration
- MUL_DIV_UNIT_DIV_EN defined: full behaviour as above.
- MUL_DIV_UNIT_DIV_EN undefined: the divider datapath is removed.
  - DIV/DIVU start is still accepted, with normal busy/done timing.
  - HI and LO are left unchanged.
  - Multiply behaviour is identical.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> at E33 HI=0xFFFFFFFE, LO=0x00000001, o_done one-cycle pulse, o_busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2; DIV 5/0 -> LO=0xFFFFFFFF, HI=5.
- MTHI 0x1234 and MTLO 0x5678 in IDLE -> visible next cycle; an MTLO issued while busy -> dropped, LO = op result at E33.
- i_rst_n pulled low at cycle 10 of a DIVU -> HI=LO=0, o_busy=0 immediately. A new MULTU 3×5 after release -> LO=15, HI=0.
- Build without MUL_DIV_UNIT_DIV_EN: preload HI=0xAA, LO=0xBB, run DIV 9/3 -> done at E33, HI=0xAA, LO=0xBB; MULTU 6×7 -> LO=42.
